decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  RV32I(+optional M, SYSTEM) decode stage that sits between fetch and execute.
//  Decodes one 32-bit instruction per accepted beat into the codebase's 8-bit instruction code, register
//  indices, immediate, CSR address and class one-hot. Results are buffered in a DEPTH-entry FIFO and
//  presented with valid/ready handshakes on both sides. Adds PC pass-through, illegal-instruction flagging and flush.
// PARAMETERS
//  DEPTH     2  decoded-entry FIFO depth; power of two, >=2
//  EN_M_EXT  0  1: decode MUL..REMU (opcode 0110011, funct7 0000001); 0: flag them illegal
//  EN_SYS    1  1: decode ECALL/EBREAK/CSR*; 0: opcode 1110011 is illegal
// PORTS
//  clk_i          in   1   clock, rising edge
//  rst_n_i        in   1   asynchronous reset, active low
//  in_valid_i     in   1   fetch offers in_inst_i/in_pc_i
//  in_ready_o     out  1   stage can accept (FIFO not full)
//  in_inst_i      in   32  raw instruction
//  in_pc_i        in   32  instruction address
//  flush_i        in   1   discard all buffered entries and the current input beat
//  out_valid_o    out  1   head entry valid
//  out_ready_i    in   1   execute consumes head entry
//  out_pc_o       out  32  PC of head entry
//  out_inst_o     out  8   instruction code (inst_def.v); 8'h00 when illegal
//  out_reg_dr_o   out  5   rd, 0 if the instruction writes no rd
//  out_reg_sr1_o  out  5   rs1, 0 if unused
//  out_reg_sr2_o  out  5   rs2, 0 if unused
//  out_imm_o      out  32  immediate, formatted per type (I/S/B/U/J, shamt, zimm); 0 for R-type
//  out_csr_addr_o out  12  inst[31:20] for CSR ops, else 0
//  out_class_o    out  13  one-hot class: LUI AUIPC JAL JALR BR LD ST OPIMM OP FENCE CSR CSRI MULDIV
//  out_illegal_o  out  1   head entry is an illegal/unsupported encoding
// BEHAVIOUR
//  Reset (rst_n_i=0, async): FIFO empty, pointers/count 0. All out_* = 0. in_ready_o = 1.
//  Accept: push when in_valid_i && in_ready_o && !flush_i. Pop when out_valid_o && out_ready_i.
//  Latency: an instruction accepted at edge N is on out_* with out_valid_o=1 after edge N (1 cycle). No bypass.
//  in_ready_o = (count != DEPTH), derived from registered count only; it never depends on out_ready_i.
//    When full, a simultaneous pop does not allow a push in the same cycle.
//  Push+pop in the same cycle with 0<count<DEPTH: count unchanged, order preserved.
//  out_* present the head entry; when empty, every payload output is forced to 0.
//  Head entry and out_* stay stable while out_valid_o && !out_ready_i.
//  Pointers are log2(DEPTH) bits wide and wrap naturally; count is log2(DEPTH)+1 bits wide.
//  flush_i: next edge sets count=0 and pointers=0. The input beat in that cycle is dropped; a pop in that
//    cycle is still counted as taken by the consumer. flush_i has priority over push/pop.
//  Decode rules: same field mapping as the RV32I base decoder (B/J immediates sign-extended, LSB 0;
//    SLTIU immediate zero-extended; shifts give shamt in imm[4:0]; CSRxI give zimm in imm[4:0]).
//  Illegal: unknown opcode, reserved funct3/funct7, shift with inst[25]=1, or an extension that is disabled.
//    Result: illegal=1, code 8'h00, class 0, regs/imm/csr 0, PC kept. The entry is still queued in order.
//  ECALL (0x00000073) and EBREAK (0x00100073) decode to new codes `ECALL/`EBREAK, class CSR, regs 0.
//  Reset asserted mid-operation: FIFO contents lost immediately; no output glitch beyond the async clear.
// STRUCTURE
//  Shared include inst_def.v: existing codes plus new `MUL..`REMU, `ECALL, `EBREAK, `ILLEGAL (8'h00),
//    class bit indices `CLS_*, and `CLS_W = 13.
//  Sub-module rv32_inst_dec: purely combinational, inst[31:0] -> decoded record; takes EN_M_EXT and EN_SYS.
//  decode_stage: FIFO storage {pc, code, rd, rs1, rs2, imm, csr, class, illegal}, pointers, count, handshake.
// TESTING
//  1 Reset, push 0xFFF00093 (ADDI x1,x0,-1), pc=0x100, out_ready=1 -> next cycle out_valid=1, ADDI, dr=1,
//    sr1=0, imm=0xFFFFFFFF, class=OPIMM, pc=0x100.
//  2 out_ready=0, push BEQ 0x00208463 back-to-back -> in_ready falls after DEPTH accepts; head holds
//    imm=0x8, sr1=1, sr2=2 with dr=0; releasing ready drains in order.
//  3 0x02208033 with EN_M_EXT=0 -> illegal=1, code 0; with EN_M_EXT=1 -> MUL, sr1=1, sr2=2, class=MULDIV.
//  4 0x00000000 and 0x40001013 (SLLI with inst[30] set) -> illegal=1, and the PC still passes through.
//  5 FIFO full, then flush_i=1 together with in_valid_i=1 -> next cycle out_valid=0, in_ready=1, the input beat
//    is never output.
//  6 rst_n_i pulsed low mid-stream -> all outputs 0 asynchronously; the first instruction after release
//    decodes correctly.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: opcodes, 8-bit instruction codes, class bit indices and decoded/FIFO records.
package decode_stage_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [7:0] OP_ILLEGAL = 8'h00;
  localparam logic [7:0] OP_LUI     = 8'h01;
  localparam logic [7:0] OP_AUIPC   = 8'h02;
  localparam logic [7:0] OP_JAL     = 8'h03;
  localparam logic [7:0] OP_JALR    = 8'h04;
  localparam logic [7:0] OP_BEQ     = 8'h05;
  localparam logic [7:0] OP_BNE     = 8'h06;
  localparam logic [7:0] OP_BLT     = 8'h07;
  localparam logic [7:0] OP_BGE     = 8'h08;
  localparam logic [7:0] OP_BLTU    = 8'h09;
  localparam logic [7:0] OP_BGEU    = 8'h0A;
  localparam logic [7:0] OP_LB      = 8'h0B;
  localparam logic [7:0] OP_LH      = 8'h0C;
  localparam logic [7:0] OP_LW      = 8'h0D;
  localparam logic [7:0] OP_LBU     = 8'h0E;
  localparam logic [7:0] OP_LHU     = 8'h0F;
  localparam logic [7:0] OP_SB      = 8'h10;
  localparam logic [7:0] OP_SH      = 8'h11;
  localparam logic [7:0] OP_SW      = 8'h12;
  localparam logic [7:0] OP_ADDI    = 8'h13;
  localparam logic [7:0] OP_SLTI    = 8'h14;
  localparam logic [7:0] OP_SLTIU   = 8'h15;
  localparam logic [7:0] OP_XORI    = 8'h16;
  localparam logic [7:0] OP_ORI     = 8'h17;
  localparam logic [7:0] OP_ANDI    = 8'h18;
  localparam logic [7:0] OP_SLLI    = 8'h19;
  localparam logic [7:0] OP_SRLI    = 8'h1A;
  localparam logic [7:0] OP_SRAI    = 8'h1B;
  localparam logic [7:0] OP_ADD     = 8'h1C;
  localparam logic [7:0] OP_SUB     = 8'h1D;
  localparam logic [7:0] OP_SLL     = 8'h1E;
  localparam logic [7:0] OP_SLT     = 8'h1F;
  localparam logic [7:0] OP_SLTU    = 8'h20;
  localparam logic [7:0] OP_XOR     = 8'h21;
  localparam logic [7:0] OP_SRL     = 8'h22;
  localparam logic [7:0] OP_SRA     = 8'h23;
  localparam logic [7:0] OP_OR      = 8'h24;
  localparam logic [7:0] OP_AND     = 8'h25;
  localparam logic [7:0] OP_FENCE   = 8'h26;
  localparam logic [7:0] OP_CSRRW   = 8'h27;
  localparam logic [7:0] OP_CSRRS   = 8'h28;
  localparam logic [7:0] OP_CSRRC   = 8'h29;
  localparam logic [7:0] OP_CSRRWI  = 8'h2A;
  localparam logic [7:0] OP_CSRRSI  = 8'h2B;
  localparam logic [7:0] OP_CSRRCI  = 8'h2C;
  // MUL..REMU are contiguous in funct3 order so the decoder can add funct3 to OP_MUL.
  localparam logic [7:0] OP_MUL     = 8'h2D;
  localparam logic [7:0] OP_MULH    = 8'h2E;
  localparam logic [7:0] OP_MULHSU  = 8'h2F;
  localparam logic [7:0] OP_MULHU   = 8'h30;
  localparam logic [7:0] OP_DIV     = 8'h31;
  localparam logic [7:0] OP_DIVU    = 8'h32;
  localparam logic [7:0] OP_REM     = 8'h33;
  localparam logic [7:0] OP_REMU    = 8'h34;
  localparam logic [7:0] OP_ECALL   = 8'h35;
  localparam logic [7:0] OP_EBREAK  = 8'h36;

  localparam int CLS_W      = 13;
  localparam int CLS_LUI    = 0;
  localparam int CLS_AUIPC  = 1;
  localparam int CLS_JAL    = 2;
  localparam int CLS_JALR   = 3;
  localparam int CLS_BR     = 4;
  localparam int CLS_LD     = 5;
  localparam int CLS_ST     = 6;
  localparam int CLS_OPIMM  = 7;
  localparam int CLS_OP     = 8;
  localparam int CLS_FENCE  = 9;
  localparam int CLS_CSR    = 10;
  localparam int CLS_CSRI   = 11;
  localparam int CLS_MULDIV = 12;

  typedef struct packed {
    logic [7:0]       code;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [31:0]      imm;
    logic [11:0]      csr;
    logic [CLS_W-1:0] cls;
    logic             illegal;
  } dec_t;

  typedef struct packed {
    logic [31:0] pc;
    dec_t        dec;
  } entry_t;

  function automatic logic [CLS_W-1:0] cls_bit(input int idx);
    logic [CLS_W-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/decode_stage_inst_dec.sv
// Combinational RV32I(+M, SYSTEM) decoder: raw instruction word to decoded record.
// Illegal or disabled encodings collapse to an all-zero record with only the illegal flag set.
module rv32_inst_dec
  import decode_stage_pkg::*;
#(
  parameter bit EN_M_EXT = 1'b0,
  parameter bit EN_SYS   = 1'b1
) (
  input  logic [31:0] inst_i,
  output dec_t        dec_o
);

  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
  dec_t        d;
  logic        legal;

  assign opcode = inst_i[6:0];
  assign rd     = inst_i[11:7];
  assign f3     = inst_i[14:12];
  assign rs1    = inst_i[19:15];
  assign rs2    = inst_i[24:20];
  assign f7     = inst_i[31:25];

  assign imm_i  = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_s  = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign imm_b  = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_u  = {inst_i[31:12], 12'b0};
  assign imm_j  = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  assign imm_sh = {27'b0, inst_i[24:20]};

  always_comb begin
    d     = '0;
    legal = 1'b1;
    case (opcode)
      OPC_LUI:   begin d.code = OP_LUI;   d.rd = rd; d.imm = imm_u; d.cls = cls_bit(CLS_LUI);   end
      OPC_AUIPC: begin d.code = OP_AUIPC; d.rd = rd; d.imm = imm_u; d.cls = cls_bit(CLS_AUIPC); end
      OPC_JAL:   begin d.code = OP_JAL;   d.rd = rd; d.imm = imm_j; d.cls = cls_bit(CLS_JAL);   end
      OPC_JALR: begin
        d.code = OP_JALR; d.rd = rd; d.rs1 = rs1; d.imm = imm_i; d.cls = cls_bit(CLS_JALR);
        legal  = (f3 == 3'b000);
      end
      OPC_BRANCH: begin
        d.rs1 = rs1; d.rs2 = rs2; d.imm = imm_b; d.cls = cls_bit(CLS_BR);
        case (f3)
          3'b000:  d.code = OP_BEQ;
          3'b001:  d.code = OP_BNE;
          3'b100:  d.code = OP_BLT;
          3'b101:  d.code = OP_BGE;
          3'b110:  d.code = OP_BLTU;
          3'b111:  d.code = OP_BGEU;
          default: legal  = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        d.rd = rd; d.rs1 = rs1; d.imm = imm_i; d.cls = cls_bit(CLS_LD);
        case (f3)
          3'b000:  d.code = OP_LB;
          3'b001:  d.code = OP_LH;
          3'b010:  d.code = OP_LW;
          3'b100:  d.code = OP_LBU;
          3'b101:  d.code = OP_LHU;
          default: legal  = 1'b0;
        endcase
      end
      OPC_STORE: begin
        d.rs1 = rs1; d.rs2 = rs2; d.imm = imm_s; d.cls = cls_bit(CLS_ST);
        case (f3)
          3'b000:  d.code = OP_SB;
          3'b001:  d.code = OP_SH;
          3'b010:  d.code = OP_SW;
          default: legal  = 1'b0;
        endcase
      end
      OPC_OPIMM: begin
        d.rd = rd; d.rs1 = rs1; d.imm = imm_i; d.cls = cls_bit(CLS_OPIMM);
        case (f3)
          3'b000: d.code = OP_ADDI;
          3'b010: d.code = OP_SLTI;
          3'b011: begin d.code = OP_SLTIU; d.imm = {20'b0, inst_i[31:20]}; end
          3'b100: d.code = OP_XORI;
          3'b110: d.code = OP_ORI;
          3'b111: d.code = OP_ANDI;
          3'b001: begin d.code = OP_SLLI; d.imm = imm_sh; legal = (f7 == 7'b0000000); end
          default: begin
            d.imm = imm_sh;
            if (f7 == 7'b0000000)      d.code = OP_SRLI;
            else if (f7 == 7'b0100000) d.code = OP_SRAI;
            else                       legal  = 1'b0;
          end
        endcase
      end
      OPC_OP: begin
        d.rd = rd; d.rs1 = rs1; d.rs2 = rs2; d.cls = cls_bit(CLS_OP);
        if (f7 == 7'b0000001) begin
          d.code = OP_MUL + {5'b0, f3};
          d.cls  = cls_bit(CLS_MULDIV);
          legal  = EN_M_EXT;
        end else if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  d.code = OP_ADD;
            3'b001:  d.code = OP_SLL;
            3'b010:  d.code = OP_SLT;
            3'b011:  d.code = OP_SLTU;
            3'b100:  d.code = OP_XOR;
            3'b101:  d.code = OP_SRL;
            3'b110:  d.code = OP_OR;
            default: d.code = OP_AND;
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          d.code = OP_SUB;
        end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
          d.code = OP_SRA;
        end else begin
          legal = 1'b0;
        end
      end
      OPC_FENCE: begin
        d.code = OP_FENCE; d.imm = imm_i; d.cls = cls_bit(CLS_FENCE);
        legal  = (f3 == 3'b000);
      end
      OPC_SYSTEM: begin
        d.csr = inst_i[31:20]; d.rd = rd;
        case (f3)
          3'b000: begin
            d.csr = '0; d.rd = '0; d.cls = cls_bit(CLS_CSR);
            if (inst_i == 32'h0000_0073)      d.code = OP_ECALL;
            else if (inst_i == 32'h0010_0073) d.code = OP_EBREAK;
            else                              legal  = 1'b0;
          end
          3'b001: begin d.code = OP_CSRRW;  d.rs1 = rs1; d.cls = cls_bit(CLS_CSR);  end
          3'b010: begin d.code = OP_CSRRS;  d.rs1 = rs1; d.cls = cls_bit(CLS_CSR);  end
          3'b011: begin d.code = OP_CSRRC;  d.rs1 = rs1; d.cls = cls_bit(CLS_CSR);  end
          3'b101: begin d.code = OP_CSRRWI; d.imm = {27'b0, rs1}; d.cls = cls_bit(CLS_CSRI); end
          3'b110: begin d.code = OP_CSRRSI; d.imm = {27'b0, rs1}; d.cls = cls_bit(CLS_CSRI); end
          3'b111: begin d.code = OP_CSRRCI; d.imm = {27'b0, rs1}; d.cls = cls_bit(CLS_CSRI); end
          default: legal = 1'b0;
        endcase
        if (!EN_SYS) legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase

    dec_o = d;
    if (!legal) begin
      dec_o         = '0;
      dec_o.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: decodes each accepted instruction and queues it in a DEPTH-entry FIFO, 1-cycle latency.
// in_ready_o depends only on the registered count (no pop-through when full); flush drops queue and input beat.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter bit EN_M_EXT = 1'b0,
  parameter bit EN_SYS   = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [31:0]       in_inst_i,
  input  logic [31:0]       in_pc_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [31:0]       out_pc_o,
  output logic [7:0]        out_inst_o,
  output logic [4:0]        out_reg_dr_o,
  output logic [4:0]        out_reg_sr1_o,
  output logic [4:0]        out_reg_sr2_o,
  output logic [31:0]       out_imm_o,
  output logic [11:0]       out_csr_addr_o,
  output logic [CLS_W-1:0]  out_class_o,
  output logic              out_illegal_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  entry_t        mem_q [DEPTH];
  entry_t        head;
  dec_t          dec;
  logic          push, pop;

  rv32_inst_dec #(
    .EN_M_EXT (EN_M_EXT),
    .EN_SYS   (EN_SYS)
  ) u_dec (
    .inst_i (in_inst_i),
    .dec_o  (dec)
  );

  assign in_ready_o  = (count_q != FULL_CNT);
  assign out_valid_o = (count_q != '0);
  assign push        = in_valid_i && in_ready_o && !flush_i;
  assign pop         = out_valid_o && out_ready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an empty count masks every payload output.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= '{pc: in_pc_i, dec: dec};
  end

  assign head = out_valid_o ? mem_q[rd_ptr_q] : '0;

  assign out_pc_o       = head.pc;
  assign out_inst_o     = head.dec.code;
  assign out_reg_dr_o   = head.dec.rd;
  assign out_reg_sr1_o  = head.dec.rs1;
  assign out_reg_sr2_o  = head.dec.rs2;
  assign out_imm_o      = head.dec.imm;
  assign out_csr_addr_o = head.dec.csr;
  assign out_class_o    = head.dec.cls;
  assign out_illegal_o  = head.dec.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: two instances differing only in EN_M_EXT share all inputs.
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic clk_i = 1'b0;
  logic rst_n_i, in_valid_i, flush_i, out_ready_i;
  logic [31:0] in_inst_i, in_pc_i;

  logic in_ready_o, out_valid_o, out_illegal_o;
  logic [31:0] out_pc_o, out_imm_o;
  logic [7:0] out_inst_o;
  logic [4:0] out_reg_dr_o, out_reg_sr1_o, out_reg_sr2_o;
  logic [11:0] out_csr_addr_o;
  logic [CLS_W-1:0] out_class_o;

  logic m_in_ready, m_out_valid, m_illegal;
  logic [31:0] m_pc, m_imm;
  logic [7:0] m_inst;
  logic [4:0] m_dr, m_sr1, m_sr2;
  logic [11:0] m_csr;
  logic [CLS_W-1:0] m_class;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  decode_stage #(.DEPTH(2), .EN_M_EXT(1'b0), .EN_SYS(1'b1)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_inst_i(in_inst_i), .in_pc_i(in_pc_i), .flush_i(flush_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_pc_o(out_pc_o),
    .out_inst_o(out_inst_o), .out_reg_dr_o(out_reg_dr_o), .out_reg_sr1_o(out_reg_sr1_o),
    .out_reg_sr2_o(out_reg_sr2_o), .out_imm_o(out_imm_o), .out_csr_addr_o(out_csr_addr_o),
    .out_class_o(out_class_o), .out_illegal_o(out_illegal_o)
  );

  decode_stage #(.DEPTH(2), .EN_M_EXT(1'b1), .EN_SYS(1'b1)) dut_m (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .in_valid_i(in_valid_i), .in_ready_o(m_in_ready),
    .in_inst_i(in_inst_i), .in_pc_i(in_pc_i), .flush_i(flush_i),
    .out_valid_o(m_out_valid), .out_ready_i(out_ready_i), .out_pc_o(m_pc),
    .out_inst_o(m_inst), .out_reg_dr_o(m_dr), .out_reg_sr1_o(m_sr1),
    .out_reg_sr2_o(m_sr2), .out_imm_o(m_imm), .out_csr_addr_o(m_csr),
    .out_class_o(m_class), .out_illegal_o(m_illegal)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc);
    in_valid_i = 1'b1;
    in_inst_i  = inst;
    in_pc_i    = pc;
  endtask

  task automatic check_head(input string tag, input logic [31:0] pc, input logic [7:0] code,
                            input logic [4:0] dr, input logic [4:0] sr1, input logic [4:0] sr2,
                            input logic [31:0] imm, input logic [11:0] csr,
                            input logic [CLS_W-1:0] cls, input logic ill);
    check_eq({tag, ".vld"}, 32'(out_valid_o), 32'd1);
    check_eq({tag, ".pc"},  out_pc_o, pc);
    check_eq({tag, ".code"}, 32'(out_inst_o), 32'(code));
    check_eq({tag, ".dr"},  32'(out_reg_dr_o), 32'(dr));
    check_eq({tag, ".sr1"}, 32'(out_reg_sr1_o), 32'(sr1));
    check_eq({tag, ".sr2"}, 32'(out_reg_sr2_o), 32'(sr2));
    check_eq({tag, ".imm"}, out_imm_o, imm);
    check_eq({tag, ".csr"}, 32'(out_csr_addr_o), 32'(csr));
    check_eq({tag, ".cls"}, 32'(out_class_o), 32'(cls));
    check_eq({tag, ".ill"}, 32'(out_illegal_o), 32'(ill));
  endtask

  initial begin
    rst_n_i = 1'b0; in_valid_i = 1'b0; in_inst_i = '0; in_pc_i = '0;
    flush_i = 1'b0; out_ready_i = 1'b0;
    repeat (2) tick();
    check_eq("rst.vld", 32'(out_valid_o), 32'd0);
    check_eq("rst.rdy", 32'(in_ready_o), 32'd1);
    check_eq("rst.pc", out_pc_o, 32'd0);
    check_eq("rst.code", 32'(out_inst_o), 32'd0);
    check_eq("rst.imm", out_imm_o, 32'd0);
    rst_n_i = 1'b1;
    tick();

    // ADDI x1,x0,-1 with 1-cycle latency
    out_ready_i = 1'b1;
    drive(32'hFFF0_0093, 32'h100);
    tick();
    in_valid_i = 1'b0;
    check_head("addi", 32'h100, OP_ADDI, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 12'h0, cls_bit(CLS_OPIMM), 1'b0);
    tick();
    check_eq("addi.drain", 32'(out_valid_o), 32'd0);

    // BEQ back-to-back with consumer stalled until full
    out_ready_i = 1'b0;
    drive(32'h0020_8463, 32'h200);
    tick();
    check_eq("beq.rdy1", 32'(in_ready_o), 32'd1);
    in_pc_i = 32'h204;
    tick();
    check_eq("beq.full", 32'(in_ready_o), 32'd0);
    in_pc_i = 32'h208;
    tick();
    in_valid_i = 1'b0;
    check_eq("beq.stillfull", 32'(in_ready_o), 32'd0);
    check_head("beq", 32'h200, OP_BEQ, 5'd0, 5'd1, 5'd2, 32'h8, 12'h0, cls_bit(CLS_BR), 1'b0);
    out_ready_i = 1'b1;
    tick();
    check_eq("beq.second.pc", out_pc_o, 32'h204);
    check_eq("beq.second.vld", 32'(out_valid_o), 32'd1);
    tick();
    check_eq("beq.empty", 32'(out_valid_o), 32'd0);

    // MUL: illegal without M, decoded with M
    drive(32'h0220_8033, 32'h300);
    tick();
    in_valid_i = 1'b0;
    check_head("mul.noM", 32'h300, OP_ILLEGAL, 5'd0, 5'd0, 5'd0, 32'h0, 12'h0, '0, 1'b1);
    check_eq("mul.M.code", 32'(m_inst), 32'(OP_MUL));
    check_eq("mul.M.sr1", 32'(m_sr1), 32'd1);
    check_eq("mul.M.sr2", 32'(m_sr2), 32'd2);
    check_eq("mul.M.cls", 32'(m_class), 32'(cls_bit(CLS_MULDIV)));
    check_eq("mul.M.ill", 32'(m_illegal), 32'd0);
    check_eq("mul.M.pc", m_pc, 32'h300);

    // Illegal encodings, each pushed while the previous head pops
    drive(32'h0000_0000, 32'h400);
    tick();
    check_head("zero", 32'h400, OP_ILLEGAL, 5'd0, 5'd0, 5'd0, 32'h0, 12'h0, '0, 1'b1);
    drive(32'h4000_1013, 32'h404);
    tick();
    check_head("slli30", 32'h404, OP_ILLEGAL, 5'd0, 5'd0, 5'd0, 32'h0, 12'h0, '0, 1'b1);
    drive(32'h0080_00EF, 32'h408);
    tick();
    check_head("jal", 32'h408, OP_JAL, 5'd1, 5'd0, 5'd0, 32'h8, 12'h0, cls_bit(CLS_JAL), 1'b0);
    drive(32'h3003_D2F3, 32'h40C);
    tick();
    check_head("csrrwi", 32'h40C, OP_CSRRWI, 5'd5, 5'd0, 5'd0, 32'h7, 12'h300, cls_bit(CLS_CSRI), 1'b0);
    drive(32'h0000_0073, 32'h410);
    tick();
    check_head("ecall", 32'h410, OP_ECALL, 5'd0, 5'd0, 5'd0, 32'h0, 12'h0, cls_bit(CLS_CSR), 1'b0);
    drive(32'h1234_50B7, 32'h414);
    tick();
    in_valid_i = 1'b0;
    check_head("lui", 32'h414, OP_LUI, 5'd1, 5'd0, 5'd0, 32'h1234_5000, 12'h0, cls_bit(CLS_LUI), 1'b0);
    tick();
    check_eq("dec.empty", 32'(out_valid_o), 32'd0);

    // Flush while full, with a live input beat
    out_ready_i = 1'b0;
    drive(32'hFFF0_0093, 32'h500);
    tick();
    in_pc_i = 32'h504;
    tick();
    check_eq("flush.pre.rdy", 32'(in_ready_o), 32'd0);
    flush_i = 1'b1;
    in_pc_i = 32'h508;
    tick();
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    check_eq("flush.vld", 32'(out_valid_o), 32'd0);
    check_eq("flush.rdy", 32'(in_ready_o), 32'd1);
    check_eq("flush.pc", out_pc_o, 32'h0);
    out_ready_i = 1'b1;
    tick();
    check_eq("flush.nobeat", 32'(out_valid_o), 32'd0);

    // Push and pop together at count 1 keeps one entry
    out_ready_i = 1'b0;
    drive(32'hFFF0_0093, 32'h600);
    tick();
    out_ready_i = 1'b1;
    in_pc_i = 32'h604;
    tick();
    in_valid_i = 1'b0;
    check_eq("pp.vld", 32'(out_valid_o), 32'd1);
    check_eq("pp.pc", out_pc_o, 32'h604);
    tick();
    check_eq("pp.empty", 32'(out_valid_o), 32'd0);

    // Asynchronous reset mid-stream
    out_ready_i = 1'b0;
    drive(32'h0020_8463, 32'h700);
    tick();
    in_pc_i = 32'h704;
    tick();
    in_valid_i = 1'b0;
    #2 rst_n_i = 1'b0;
    #1;
    check_eq("arst.vld", 32'(out_valid_o), 32'd0);
    check_eq("arst.pc", out_pc_o, 32'h0);
    check_eq("arst.code", 32'(out_inst_o), 32'd0);
    check_eq("arst.rdy", 32'(in_ready_o), 32'd1);
    #1 rst_n_i = 1'b1;
    tick();
    out_ready_i = 1'b1;
    drive(32'hFFF0_0093, 32'h800);
    tick();
    in_valid_i = 1'b0;
    check_head("post", 32'h800, OP_ADDI, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 12'h0, cls_bit(CLS_OPIMM), 1'b0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
